// File: rtl/vend_dispense.sv
`default_nettype none
// ============================================================================
// Module      : vend_dispense
// Description : Vending sale sequencer: selection check, coin credit, vend,
//               change and refund. Define VEND_CHANGE_EN to return overpayment.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_dispense #(
    parameter logic [7:0] PRICE0 = 8'd10,
    parameter logic [7:0] PRICE1 = 8'd15,
    parameter logic [7:0] PRICE2 = 8'd20,
    parameter logic [7:0] PRICE3 = 8'd25,
    parameter logic [7:0] PRICE4 = 8'd30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] stock,
    input  logic        select_valid,
    input  logic [2:0]  select_slot,
    input  logic        coin_valid,
    input  logic [1:0]  coin,
    input  logic        cancel,
    output logic        take_valid,
    output logic [2:0]  take_slot,
    output logic        change_valid,
    output logic [7:0]  change_amount,
    output logic        coin_reject,
    output logic        error,
    output logic [7:0]  credit
);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_CHECK  = 3'd1;
    localparam logic [2:0] c_S_PAY    = 3'd2;
    localparam logic [2:0] c_S_VEND   = 3'd3;
    localparam logic [2:0] c_S_CHANGE = 3'd4;
    localparam logic [2:0] c_S_REFUND = 3'd5;

    logic [2:0] r_state;
    logic [2:0] r_slot;
    logic [7:0] r_price;
    logic [7:0] r_credit;

    logic [7:0] w_coin_value;
    logic [7:0] w_sel_price;
    logic [3:0] w_stock_cnt;
    logic [8:0] w_sum;
    logic       w_coin_ok;

    always_comb begin
        w_coin_value = 8'd1;
        case (coin)
            2'b00:   w_coin_value = 8'd1;
            2'b01:   w_coin_value = 8'd5;
            2'b10:   w_coin_value = 8'd10;
            default: w_coin_value = 8'd25;
        endcase
    end

    always_comb begin
        w_sel_price = 8'd0;
        case (select_slot)
            3'd0:    w_sel_price = PRICE0;
            3'd1:    w_sel_price = PRICE1;
            3'd2:    w_sel_price = PRICE2;
            3'd3:    w_sel_price = PRICE3;
            3'd4:    w_sel_price = PRICE4;
            default: w_sel_price = 8'd0;
        endcase
    end

    always_comb begin
        w_stock_cnt = 4'd0;
        case (r_slot)
            3'd0:    w_stock_cnt = stock[3:0];
            3'd1:    w_stock_cnt = stock[7:4];
            3'd2:    w_stock_cnt = stock[11:8];
            3'd3:    w_stock_cnt = stock[15:12];
            3'd4:    w_stock_cnt = stock[19:16];
            default: w_stock_cnt = 4'd0;
        endcase
    end

    // Ninth bit of the sum flags a credit that would exceed 255.
    assign w_sum     = {1'b0, r_credit} + {1'b0, w_coin_value};
    assign w_coin_ok = coin_valid && (r_state == c_S_PAY) && !cancel && !w_sum[8];
    assign credit    = r_credit;

`ifdef VEND_CHANGE_EN
    logic [7:0] w_overpay;
    assign w_overpay = r_credit - r_price;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_S_IDLE;
            r_slot        <= 3'd0;
            r_price       <= 8'd0;
            r_credit      <= 8'd0;
            take_valid    <= 1'b0;
            take_slot     <= 3'd0;
            change_valid  <= 1'b0;
            change_amount <= 8'd0;
            coin_reject   <= 1'b0;
            error         <= 1'b0;
        end else begin
            take_valid    <= 1'b0;
            take_slot     <= 3'd0;
            change_valid  <= 1'b0;
            change_amount <= 8'd0;
            coin_reject   <= coin_valid && !w_coin_ok;
            error         <= 1'b0;

            case (r_state)
                c_S_IDLE: begin
                    if (select_valid) begin
                        r_slot  <= select_slot;
                        r_price <= w_sel_price;
                        r_state <= c_S_CHECK;
                    end
                end
                c_S_CHECK: begin
                    if ((r_slot > 3'd4) || (w_stock_cnt == 4'd0)) begin
                        error   <= 1'b1;
                        r_state <= c_S_IDLE;
                    end else begin
                        r_state <= c_S_PAY;
                    end
                end
                c_S_PAY: begin
                    if (cancel) begin
                        r_state <= c_S_REFUND;
                    end else if (w_coin_ok) begin
                        r_credit <= w_sum[7:0];
                        if (w_sum[7:0] >= r_price) begin
                            r_state <= c_S_VEND;
                        end
                    end
                end
                c_S_VEND: begin
                    take_valid <= 1'b1;
                    take_slot  <= r_slot;
                    r_state    <= c_S_CHANGE;
                end
                c_S_CHANGE: begin
`ifdef VEND_CHANGE_EN
                    if (w_overpay != 8'd0) begin
                        change_valid  <= 1'b1;
                        change_amount <= w_overpay;
                    end
`endif
                    r_credit <= 8'd0;
                    r_state  <= c_S_IDLE;
                end
                c_S_REFUND: begin
                    if (r_credit != 8'd0) begin
                        change_valid  <= 1'b1;
                        change_amount <= r_credit;
                    end
                    r_credit <= 8'd0;
                    r_state  <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
